// File: rtl/dc_ctrl_pkg.sv
// Shared types for the data-cache line refill/writeback sequencer.
// No logic or latency; the enum and sizes are used by dc_line_ctrl and dc_line_buf.
package dc_ctrl_pkg;
    localparam int LINE_WORDS = 4;
    localparam int BEAT_W     = 2;
    localparam int LINE_W     = 32 * LINE_WORDS;

    typedef enum logic [2:0] {
        IDLE,
        WB_RD,
        WB_CAP,
        WB,
        FILL,
        FILL_WR,
        DONE
    } dc_state_t;
endpackage

// File: rtl/dc_line_buf.sv
// 128-bit line buffer: whole-line load, per-word write, word-select read.
// Writes land one cycle after the request; the read port is combinational and never stalls.
module dc_line_buf
    import dc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LINE_W-1:0] load_dat,
    input  logic              wr,
    input  logic [BEAT_W-1:0] wr_idx,
    input  logic [31:0]       wr_dat,
    input  logic [BEAT_W-1:0] rd_idx,
    output logic [31:0]       rd_word,
    output logic [LINE_W-1:0] line
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line <= '0;
        end else if (load) begin
            line <= load_dat;
        end else if (wr) begin
            line[{wr_idx, 5'd0} +: 32] <= wr_dat;
        end
    end

    assign rd_word = line[{rd_idx, 5'd0} +: 32];
endmodule

// File: rtl/dc_line_ctrl.sv
// D-cache miss sequencer: optional dirty-victim writeback, 4-beat refill, line write, done pulse.
// Clean miss completes 6 cycles after acceptance with zero-wait memory; each mem_ack wait adds a cycle.
module dc_line_ctrl
    import dc_ctrl_pkg::*;
#(
    parameter int DWIDTH = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_req,
    input  logic              miss_dirty,
    input  logic [DWIDTH-3:0] miss_line_idx,
    input  logic [27:0]       victim_line_adr,
    input  logic [27:0]       fill_line_adr,
    output logic              dc_stall,
    output logic              miss_done,
    output logic              tag_update,
    output logic [DWIDTH-3:0] ram_radr_all,
    output logic              ram_ren_all,
    input  logic [LINE_W-1:0] ram_rdata_all,
    output logic [DWIDTH-3:0] ram_wadr_all,
    output logic [LINE_W-1:0] ram_wdata_all,
    output logic              ram_wen_all,
    output logic              mem_req,
    output logic              mem_we,
    output logic [29:0]       mem_adr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);
    dc_state_t         state;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] nxt_beat;
    logic [DWIDTH-3:0] idx_q;
    logic [27:0]       victim_q;
    logic [27:0]       fill_q;
    logic [LINE_W-1:0] line;
    logic [31:0]       nxt_word;
    logic              buf_load;
    logic              buf_wr;
    logic              last_beat;

    assign nxt_beat  = beat + 1'b1;
    assign last_beat = (beat == BEAT_W'(LINE_WORDS - 1));
    assign buf_load  = (state == WB_CAP);
    assign buf_wr    = (state == FILL) && mem_ack;

    dc_line_buf u_line_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (buf_load),
        .load_dat (ram_rdata_all),
        .wr       (buf_wr),
        .wr_idx   (beat),
        .wr_dat   (mem_rdata),
        .rd_idx   (nxt_beat),
        .rd_word  (nxt_word),
        .line     (line)
    );

    // Line-port address/data are qualified by their enables so the port idles at zero.
    assign ram_radr_all  = ram_ren_all ? idx_q : '0;
    assign ram_wadr_all  = ram_wen_all ? idx_q : '0;
    assign ram_wdata_all = ram_wen_all ? line  : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat        <= '0;
            idx_q       <= '0;
            victim_q    <= '0;
            fill_q      <= '0;
            dc_stall    <= 1'b0;
            miss_done   <= 1'b0;
            tag_update  <= 1'b0;
            ram_ren_all <= 1'b0;
            ram_wen_all <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_adr     <= '0;
            mem_wdata   <= '0;
        end else begin
            miss_done   <= 1'b0;
            tag_update  <= 1'b0;
            ram_ren_all <= 1'b0;
            ram_wen_all <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        idx_q    <= miss_line_idx;
                        victim_q <= victim_line_adr;
                        fill_q   <= fill_line_adr;
                        dc_stall <= 1'b1;
                        beat     <= '0;
                        if (miss_dirty) begin
                            state       <= WB_RD;
                            ram_ren_all <= 1'b1;
                        end else begin
                            // Latches are not yet visible, so the first fill address comes from the port.
                            state   <= FILL;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            mem_adr <= {fill_line_adr, 2'b00};
                        end
                    end
                end
                WB_RD: state <= WB_CAP;
                WB_CAP: begin
                    state     <= WB;
                    beat      <= '0;
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_adr   <= {victim_q, 2'b00};
                    mem_wdata <= ram_rdata_all[31:0];
                end
                WB: begin
                    if (mem_ack) begin
                        if (last_beat) begin
                            state     <= FILL;
                            beat      <= '0;
                            mem_we    <= 1'b0;
                            mem_adr   <= {fill_q, 2'b00};
                            mem_wdata <= '0;
                        end else begin
                            beat      <= nxt_beat;
                            mem_adr   <= {victim_q, nxt_beat};
                            mem_wdata <= nxt_word;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        if (last_beat) begin
                            state       <= FILL_WR;
                            beat        <= '0;
                            mem_req     <= 1'b0;
                            mem_adr     <= '0;
                            ram_wen_all <= 1'b1;
                        end else begin
                            beat    <= nxt_beat;
                            mem_adr <= {fill_q, nxt_beat};
                        end
                    end
                end
                FILL_WR: begin
                    state      <= DONE;
                    miss_done  <= 1'b1;
                    tag_update <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    dc_stall <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dc_line_ctrl.sv
// Directed bench for dc_line_ctrl with a cycle-stepped external memory responder.
module tb_dc_line_ctrl;
    import dc_ctrl_pkg::*;

    localparam int DWIDTH = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              miss_req;
    logic              miss_dirty;
    logic [DWIDTH-3:0] miss_line_idx;
    logic [27:0]       victim_line_adr;
    logic [27:0]       fill_line_adr;
    logic              dc_stall;
    logic              miss_done;
    logic              tag_update;
    logic [DWIDTH-3:0] ram_radr_all;
    logic              ram_ren_all;
    logic [127:0]      ram_rdata_all;
    logic [DWIDTH-3:0] ram_wadr_all;
    logic [127:0]      ram_wdata_all;
    logic              ram_wen_all;
    logic              mem_req;
    logic              mem_we;
    logic [29:0]       mem_adr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    dc_line_ctrl #(.DWIDTH(DWIDTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .miss_req        (miss_req),
        .miss_dirty      (miss_dirty),
        .miss_line_idx   (miss_line_idx),
        .victim_line_adr (victim_line_adr),
        .fill_line_adr   (fill_line_adr),
        .dc_stall        (dc_stall),
        .miss_done       (miss_done),
        .tag_update      (tag_update),
        .ram_radr_all    (ram_radr_all),
        .ram_ren_all     (ram_ren_all),
        .ram_rdata_all   (ram_rdata_all),
        .ram_wadr_all    (ram_wadr_all),
        .ram_wdata_all   (ram_wdata_all),
        .ram_wen_all     (ram_wen_all),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_adr         (mem_adr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Responder and observation state
    int           cyc;
    bit           resp_on;
    int           waits;
    int           wcnt;
    bit           waiting;
    logic [62:0]  hold;
    int           unstable;
    int           nb;
    logic         log_we  [16];
    logic [29:0]  log_adr [16];
    logic [31:0]  log_wd  [16];
    int           nrd;
    logic [31:0]  rd_words [4];
    logic [127:0] ram_line;
    logic         ren_prev;
    int           ren_cnt, wen_cnt, done_cnt, both_seen, tag_mis;
    int           ren_cyc, wen_cyc, done_cyc;
    logic [8:0]   ren_adr, wen_adr;
    logic [127:0] wen_dat;
    logic [31:0]  exp_w [4];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] outs_vec();
        return 128'({dc_stall, miss_done, tag_update, ram_ren_all, ram_wen_all, mem_req, mem_we,
                     ram_radr_all, ram_wadr_all, mem_adr, mem_wdata});
    endfunction

    task automatic clear_log();
        wcnt = 0; waiting = 1'b0; hold = '0; unstable = 0; nb = 0; nrd = 0;
        ren_prev = 1'b0; ren_cnt = 0; wen_cnt = 0; done_cnt = 0; both_seen = 0; tag_mis = 0;
        ren_cyc = 0; wen_cyc = 0; done_cyc = 0; ren_adr = '0; wen_adr = '0; wen_dat = '0;
    endtask

    task automatic set_rd(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
        rd_words[0] = a; rd_words[1] = b; rd_words[2] = c; rd_words[3] = d;
    endtask

    // One clock: step past the edge, observe outputs, drive this cycle's responses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        ram_rdata_all = ren_prev ? ram_line : '0;
        ren_prev = ram_ren_all;
        if (ram_ren_all && ram_wen_all) both_seen++;
        if (ram_ren_all) begin ren_cnt++; ren_cyc = cyc; ren_adr = ram_radr_all; end
        if (ram_wen_all) begin wen_cnt++; wen_cyc = cyc; wen_adr = ram_wadr_all; wen_dat = ram_wdata_all; end
        if (miss_done) begin done_cnt++; done_cyc = cyc; end
        if (tag_update != miss_done) tag_mis++;
        if (waiting && !mem_req) unstable++;
        if (mem_req && resp_on) begin
            if (waiting && ({mem_we, mem_adr, mem_wdata} !== hold)) unstable++;
            if (wcnt == waits) begin
                mem_ack = 1'b1;
                if (!mem_we) begin
                    mem_rdata = rd_words[nrd & 3];
                    nrd++;
                end
                if (nb < 16) begin
                    log_we[nb] = mem_we; log_adr[nb] = mem_adr; log_wd[nb] = mem_wdata;
                end
                nb++;
                wcnt = 0;
                waiting = 1'b0;
            end else begin
                wcnt++;
                waiting = 1'b1;
                hold = {mem_we, mem_adr, mem_wdata};
            end
        end
    endtask

    task automatic do_miss(input logic dirty, input logic [8:0] idx, input logic [27:0] vadr,
                           input logic [27:0] fadr, input int w, input int rst_at, input bit scramble);
        clear_log();
        waits = w;
        resp_on = 1'b1;
        miss_req = 1'b1; miss_dirty = dirty; miss_line_idx = idx;
        victim_line_adr = vadr; fill_line_adr = fadr;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cyc == 1 && !scramble) miss_req = 1'b0;
            if (scramble && cyc == 2) begin
                miss_req = 1'b0; miss_dirty = ~dirty; miss_line_idx = '1;
                victim_line_adr = 28'hFFFFFFF; fill_line_adr = 28'h5555555;
            end
            if (rst_at != 0 && cyc == rst_at) begin
                rst_n = 1'b0;
                tick();
                check("rst_mid_outs", outs_vec(), 128'd0);
                check("rst_mid_wdata", ram_wdata_all, 128'd0);
                rst_n = 1'b1;
                break;
            end
            if (done_cyc != 0) break;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        exp_w[0] = 32'hAAAAAAAA; exp_w[1] = 32'hBBBBBBBB; exp_w[2] = 32'hCCCCCCCC; exp_w[3] = 32'hDDDDDDDD;
        rst_n = 1'b0; miss_req = 1'b0; miss_dirty = 1'b0; miss_line_idx = '0;
        victim_line_adr = '0; fill_line_adr = '0; mem_ack = 1'b0; mem_rdata = '0;
        ram_rdata_all = '0; ram_line = '0; resp_on = 1'b0; waits = 0; cyc = 0;
        clear_log();

        // Reset state
        tick(); tick();
        check("rst_outs", outs_vec(), 128'd0);
        check("rst_wdata", ram_wdata_all, 128'd0);
        rst_n = 1'b1;
        tick();
        check("idle_outs", outs_vec(), 128'd0);

        // Clean miss, zero wait
        set_rd(32'h11, 32'h22, 32'h33, 32'h44);
        do_miss(1'b0, 9'd5, 28'h0, 28'h0001000, 0, 0, 1'b0);
        check("clean_nbeats", 128'(nb), 128'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("clean_beat%0d", i), 128'({log_we[i], log_adr[i]}),
                  128'({1'b0, 30'h0004000 + 30'(i)}));
        check("clean_wen_cyc", 128'(wen_cyc), 128'd5);
        check("clean_wen_cnt", 128'(wen_cnt), 128'd1);
        check("clean_wadr", 128'(wen_adr), 128'd5);
        check("clean_wdata", wen_dat, 128'h00000044_00000033_00000022_00000011);
        check("clean_done_cyc", 128'(done_cyc), 128'd6);
        check("clean_no_ren", 128'(ren_cnt), 128'd0);
        check("clean_tag", 128'(tag_mis), 128'd0);
        tick();
        check("clean_stall_fall", 128'(dc_stall), 128'd0);

        // Dirty miss, zero wait
        ram_line = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        set_rd(32'h0BAD0000, 32'h0BAD0001, 32'h0BAD0002, 32'h0BAD0003);
        do_miss(1'b1, 9'd7, 28'h0002000, 28'h0001234, 0, 0, 1'b0);
        check("dirty_nbeats", 128'(nb), 128'd8);
        check("dirty_ren", 128'({ren_cnt[3:0], ren_cyc[7:0], ren_adr}), 128'({4'd1, 8'd1, 9'd7}));
        for (int i = 0; i < 4; i++)
            check($sformatf("dirty_wbeat%0d", i), 128'({log_we[i], log_adr[i], log_wd[i]}),
                  128'({1'b1, 30'h0008000 + 30'(i), exp_w[i]}));
        for (int i = 4; i < 8; i++)
            check($sformatf("dirty_rbeat%0d", i), 128'({log_we[i], log_adr[i]}),
                  128'({1'b0, 30'h00048D0 + 30'(i - 4)}));
        check("dirty_wen_cyc", 128'(wen_cyc), 128'd11);
        check("dirty_wdata", wen_dat, 128'h0BAD0003_0BAD0002_0BAD0001_0BAD0000);
        check("dirty_done_cyc", 128'(done_cyc), 128'd12);
        check("dirty_ren_wen_excl", 128'(both_seen), 128'd0);
        tick();

        // Wait states: each beat acked on its third cycle
        set_rd(32'h11, 32'h22, 32'h33, 32'h44);
        do_miss(1'b0, 9'd1, 28'h0, 28'h0001000, 2, 0, 1'b0);
        check("wait_nbeats", 128'(nb), 128'd4);
        check("wait_beat3", 128'(log_adr[3]), 128'h0004003);
        check("wait_stable", 128'(unstable), 128'd0);
        check("wait_wen_cyc", 128'(wen_cyc), 128'd13);
        check("wait_done_cyc", 128'(done_cyc), 128'd14);
        tick();

        // Reset during FILL beat 2 (cycle 3), then idle, then a fresh miss
        set_rd(32'h11, 32'h22, 32'h33, 32'h44);
        do_miss(1'b0, 9'd2, 28'h0, 28'h0000100, 0, 3, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("rst_idle_outs", outs_vec(), 128'd0);
        check("rst_no_wen", 128'(wen_cnt), 128'd0);
        check("rst_no_done", 128'(done_cnt), 128'd0);
        set_rd(32'h55, 32'h66, 32'h77, 32'h88);
        do_miss(1'b0, 9'd4, 28'h0, 28'h0000200, 0, 0, 1'b0);
        check("post_rst_beat0", 128'(log_adr[0]), 128'h0000800);
        check("post_rst_done", 128'(done_cyc), 128'd6);
        check("post_rst_wadr", 128'(wen_adr), 128'd4);
        check("post_rst_wdata", wen_dat, 128'h00000088_00000077_00000066_00000055);
        tick();

        // Spurious ack in IDLE is ignored
        resp_on = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b1;
        tick();
        check("spur_ack_idle", outs_vec(), 128'd0);

        // miss_req dropped in cycle 2 with inputs scrambled; latched values must win
        ram_line = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        set_rd(32'h1, 32'h2, 32'h3, 32'h4);
        do_miss(1'b1, 9'd9, 28'h0000ABC, 28'h0003000, 0, 0, 1'b1);
        check("scr_nbeats", 128'(nb), 128'd8);
        check("scr_ren_adr", 128'(ren_adr), 128'd9);
        check("scr_wbeat0", 128'({log_we[0], log_adr[0], log_wd[0]}), 128'({1'b1, 30'h0002AF0, 32'hAAAAAAAA}));
        check("scr_wbeat3", 128'({log_we[3], log_adr[3], log_wd[3]}), 128'({1'b1, 30'h0002AF3, 32'hDDDDDDDD}));
        check("scr_rbeat0", 128'({log_we[4], log_adr[4]}), 128'({1'b0, 30'h000C000}));
        check("scr_rbeat3", 128'({log_we[7], log_adr[7]}), 128'({1'b0, 30'h000C003}));
        check("scr_wadr", 128'(wen_adr), 128'd9);
        check("scr_done_cyc", 128'(done_cyc), 128'd12);
        tick();
        tick();
        check("scr_idle_after", 128'({dc_stall, mem_req}), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dc_line_ctrl.md
# dc_line_ctrl

Data-cache line refill/writeback sequencer for the RV32I memory-access stage. On a tag miss it stalls the pipeline, optionally writes the dirty victim line from the data RAM's 128-bit line port to external memory, then fetches the missing line one word at a time. It writes the assembled line back through the same line port and signals completion so the tag array can update. It is the sole master of the data RAM line port (`ram_*_all`).

## Interface
Parameters:
- `DWIDTH`, 11, data RAM word-address width; line index is `DWIDTH-2` bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `miss_req`  in  1  miss request from MA; sampled only in IDLE.
- `miss_dirty`  in  1  victim line dirty; sampled with `miss_req`.
- `miss_line_idx`  in  DWIDTH-2  cache line index of the miss.
- `victim_line_adr`  in  28  external line address `[31:4]` of the victim.
- `fill_line_adr`  in  28  external line address `[31:4]` of the missing line.
- `dc_stall`  out  1  high in every state except IDLE.
- `miss_done`  out  1  one-cycle pulse when the line is resident.
- `tag_update`  out  1  one-cycle pulse, coincident with `miss_done`.
- `ram_radr_all`  out  DWIDTH-2  line read index.
- `ram_ren_all`  out  1  line read enable.
- `ram_rdata_all`  in  128  line read data, valid one cycle after `ram_ren_all`.
- `ram_wadr_all`  out  DWIDTH-2  line write index.
- `ram_wdata_all`  out  128  line write data.
- `ram_wen_all`  out  1  line write enable.
- `mem_req`  out  1  external word request; held until acked.
- `mem_we`  out  1  1 = write beat, 0 = read beat.
- `mem_adr`  out  30  external word address `[31:2]`.
- `mem_wdata`  out  32  write beat data.
- `mem_ack`  in  1  beat accepted/complete; single-cycle; may arrive in the first `mem_req` cycle.
- `mem_rdata`  in  32  read beat data, valid with `mem_ack`.

## Operation
States:
- **IDLE** -> `miss_req`:
  - to **WB_RD** if `miss_dirty`;
  - else to **FILL**.
- Latch `miss_line_idx`, `victim_line_adr` and `fill_line_adr` on the transition.

Per state:
- **WB_RD**: `ram_ren_all`=1 with the latched index; -> **WB_CAP**.
- **WB_CAP**: capture `ram_rdata_all` into the line buffer; beat counter=0; -> **WB**.
- **WB**:
  - `mem_req`=1, `mem_we`=1;
  - `mem_adr`={victim_line_adr, beat};
  - `mem_wdata`=buffer word[beat], where word n = bits `[32n+31:32n]`;
  - each `mem_ack` increments beat; ack on beat 3 -> **FILL**, beat=0.
- **FILL**:
  - `mem_req`=1, `mem_we`=0;
  - `mem_adr`={fill_line_adr, beat};
  - on `mem_ack`, `mem_rdata` goes into buffer word[beat] and beat increments;
  - ack on beat 3 -> **FILL_WR**.
- **FILL_WR**: `ram_wen_all`=1, `ram_wadr_all`=latched index, `ram_wdata_all`=buffer with the beat-3 word included; -> **DONE**.
- **DONE**: `miss_done`=`tag_update`=1; -> IDLE.

Rules:
- Beat counter is 2 bits.
- Address and data are taken from the latched registers only; changes on the `miss_*` and `*_line_adr` inputs after acceptance are ignored.
- `miss_req` falling mid-sequence is ignored; the sequence completes.
- `miss_req` still high in the DONE cycle is not re-accepted until IDLE.
- `mem_ack` outside WB/FILL is ignored.
- `ram_ren_all` and `ram_wen_all` are never high in the same cycle.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - state=IDLE, beat=0, buffer=0, latched registers=0;
  - all outputs 0, including mid-sequence; a partially filled line is never written.
- Clean miss, zero-wait memory (`miss_req` sampled at edge 0):
  - FILL in cycles 1–4;
  - FILL_WR in cycle 5;
  - `miss_done` in cycle 6.
- Dirty miss, zero-wait memory:
  - WB_RD=1, WB_CAP=2, WB=3–6, FILL=7–10, FILL_WR=11, `miss_done`=12.
- Each wait cycle on `mem_ack` adds exactly one cycle.
- `dc_stall` rises in the cycle after acceptance and falls in the cycle after `miss_done`.
- Outputs are registered state decodes; `mem_adr` and `mem_wdata` change only on the cycle after an ack.

## Structure
- Package `dc_ctrl_pkg`:
  - state enum (IDLE, WB_RD, WB_CAP, WB, FILL, FILL_WR, DONE);
  - `LINE_WORDS`=4;
  - `BEAT_W`=2.
- Sub-module `dc_line_buf` (128-bit buffer):
  - load-all port;
  - per-word write by beat index;
  - word-select read.
- FSM and counter live in `dc_line_ctrl`.

## Test plan
- Clean miss, idx=5, fill_line_adr=0x0001000, ack every cycle, rdata 0x11,0x22,0x33,0x44:
  - reads at mem_adr 0x0004000–0x0004003;
  - `ram_wen_all` cycle 5, `ram_wdata_all`=0x00000044_00000033_00000022_00000011;
  - `miss_done` cycle 6.
- Dirty miss, `ram_rdata_all`=0xDDDD_CCCC_BBBB_AAAA (word-repeated pattern), victim 0x0002000:
  - write beats at 0x0008000–0x0008003 carry words 0..3 in order before any read beat;
  - `miss_done` cycle 12.
- Wait states (ack after 3 cycles per beat):
  - `mem_req` and `mem_adr` stable while waiting;
  - `miss_done` at cycle 6+4·2 on a clean miss.
- Reset asserted during FILL beat 2:
  - next cycle all outputs 0, state IDLE;
  - no `ram_wen_all` at any point;
  - a new miss afterwards completes normally.
- `miss_req` dropped in cycle 2 and inputs changed mid-sequence:
  - sequence completes with the originally latched addresses;
  - spurious `mem_ack` in IDLE has no effect.
